// File: rtl/filter_bank_scheduler_if.sv
// Control/strobe bundle between the CNN top-level, the filter banks and the conv core.
interface filter_bank_scheduler_if #(
  parameter int NUM_FILTERS        = 4,
  parameter int FILT_IDX_W         = 2,
  parameter int addressWidthFilter = 4
);
  logic                          start;
  logic                          abort;
  logic                          conv_done;
  logic                          mem_en;
  logic [NUM_FILTERS-1:0]        mem_sel;
  logic [addressWidthFilter-1:0] mem_addr;
  logic                          wload;
  logic                          conv_start;
  logic [FILT_IDX_W-1:0]         filter_idx;
  logic                          busy;
  logic                          done;
  logic                          aborted;

  modport master (
    output start, abort, conv_done,
    input  mem_en, mem_sel, mem_addr, wload, conv_start, filter_idx, busy, done, aborted
  );

  modport slave (
    input  start, abort, conv_done,
    output mem_en, mem_sel, mem_addr, wload, conv_start, filter_idx, busy, done, aborted
  );
endinterface

// File: rtl/filter_bank_scheduler.sv
// Walks the filter weight banks through a single conv core, one filter per pass step.
module filter_bank_scheduler #(
  parameter int NUM_FILTERS        = 4,
  parameter int FILT_IDX_W         = 2,
  parameter int addressWidthFilter = 4,
  parameter int BASE_ADDR          = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  filter_bank_scheduler_if.slave bus
);
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_LAT  = 3'd2;
  localparam logic [2:0] S_STRT = 3'd3;
  localparam logic [2:0] S_WAIT = 3'd4;
  localparam logic [2:0] S_FIN  = 3'd5;
  localparam logic [2:0] S_ABRT = 3'd6;

  localparam logic [FILT_IDX_W-1:0]         LAST_IDX = FILT_IDX_W'(NUM_FILTERS - 1);
  localparam logic [addressWidthFilter-1:0] BASE     = addressWidthFilter'(BASE_ADDR);

  logic [2:0]                    state_q, state_d;
  logic [FILT_IDX_W-1:0]         idx_q, idx_d;
  logic                          mem_en_q, mem_en_d;
  logic [NUM_FILTERS-1:0]        mem_sel_q, mem_sel_d;
  logic [addressWidthFilter-1:0] mem_addr_q, mem_addr_d;
  logic                          wload_q, wload_d;
  logic                          conv_start_q, conv_start_d;
  logic                          busy_q, busy_d;
  logic                          done_q, done_d;
  logic                          aborted_q, aborted_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.abort) begin
          state_d = S_RD;
          idx_d   = '0;
        end
      end
      S_RD:   state_d = S_LAT;
      S_LAT:  state_d = S_STRT;
      S_STRT: state_d = S_WAIT;
      S_WAIT: begin
        if (bus.conv_done) begin
          if (idx_q == LAST_IDX) begin
            state_d = S_FIN;
          end else begin
            state_d = S_RD;
            idx_d   = idx_q + FILT_IDX_W'(1);
          end
        end
      end
      S_FIN:   state_d = S_IDLE;
      S_ABRT:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // abort overrides any normal transition once a pass is underway
    if (bus.abort && (state_q != S_IDLE) && (state_q != S_ABRT)) begin
      state_d = S_ABRT;
      idx_d   = idx_q;
    end
  end

  // Outputs are decoded from the next state so they register alongside it.
  always_comb begin
    mem_en_d     = (state_d == S_RD);
    mem_sel_d    = ((state_d == S_RD) || (state_d == S_LAT)) ?
                   (NUM_FILTERS'(1) << idx_d) : '0;
    mem_addr_d   = (state_d == S_RD) ? BASE : mem_addr_q;
    wload_d      = (state_d == S_LAT);
    conv_start_d = (state_d == S_STRT);
    busy_d       = (state_d != S_IDLE);
    done_d       = (state_d == S_FIN);
    aborted_d    = (state_d == S_ABRT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      mem_en_q     <= 1'b0;
      mem_sel_q    <= '0;
      mem_addr_q   <= '0;
      wload_q      <= 1'b0;
      conv_start_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      mem_en_q     <= mem_en_d;
      mem_sel_q    <= mem_sel_d;
      mem_addr_q   <= mem_addr_d;
      wload_q      <= wload_d;
      conv_start_q <= conv_start_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
    end
  end

  assign bus.mem_en     = mem_en_q;
  assign bus.mem_sel    = mem_sel_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.wload      = wload_q;
  assign bus.conv_start = conv_start_q;
  assign bus.filter_idx = idx_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.aborted    = aborted_q;
endmodule

// File: tb/tb_filter_bank_scheduler.sv
// Directed bench: a 4-filter instance with a bank-select scoreboard, plus a 1-filter instance at BASE_ADDR=3.
module tb_filter_bank_scheduler;
  localparam int NFA = 4;

  logic clk;
  logic rst_n;

  filter_bank_scheduler_if #(.NUM_FILTERS(4), .FILT_IDX_W(2), .addressWidthFilter(4)) ba ();
  filter_bank_scheduler_if #(.NUM_FILTERS(1), .FILT_IDX_W(1), .addressWidthFilter(4)) bb ();

  filter_bank_scheduler #(.NUM_FILTERS(4), .FILT_IDX_W(2), .addressWidthFilter(4), .BASE_ADDR(0))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(ba));
  filter_bank_scheduler #(.NUM_FILTERS(1), .FILT_IDX_W(1), .addressWidthFilter(4), .BASE_ADDR(3))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(bb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int wl_cnt = 0, cs_cnt = 0, dn_cnt = 0;
  logic [31:0] sb_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic sel_ok(input logic [3:0] sel, input logic en);
    return $onehot0(sel) && (!en || (sel != 4'd0));
  endfunction

  function automatic logic [31:0] exp_rd(input int i, input int addr);
    return (32'(addr) << 4) | (32'(1) << i);
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_a"}, {ba.mem_en, ba.mem_sel, ba.mem_addr, ba.wload, ba.conv_start,
                      ba.filter_idx, ba.busy, ba.done, ba.aborted}, 32'd0);
    chk({tag, "_b"}, {bb.mem_en, bb.mem_sel, bb.mem_addr, bb.wload, bb.conv_start,
                      bb.filter_idx, bb.busy, bb.done, bb.aborted}, 32'd0);
  endtask

  task automatic tick();
    logic [31:0] e;
    @(posedge clk);
    #1;
    cyc++;
    if (ba.wload) wl_cnt++;
    if (ba.conv_start) cs_cnt++;
    if (ba.done) dn_cnt++;
    chk("wl_cs_overlap", {31'd0, ba.wload & ba.conv_start}, 32'd0);
    chk("sel_onehot_a", {31'd0, sel_ok(ba.mem_sel, ba.mem_en)}, 32'd1);
    chk("sel_onehot_b", {31'd0, sel_ok({3'd0, bb.mem_sel}, bb.mem_en)}, 32'd1);
    if (ba.mem_en) begin
      e = (sb_q.size() != 0) ? sb_q.pop_front() : 32'hFFFF_FFFF;
      chk("sb_rd_addr_sel", {24'd0, ba.mem_addr, ba.mem_sel}, e);
    end
  endtask

  // Called in the cycle after RD is entered; returns after the edge that samples conv_done.
  task automatic one_filter(input int i, input int dly, input bit noise);
    chk("rd_idx", 32'(ba.filter_idx), 32'(i));
    if (noise) ba.conv_done = 1'b1;
    tick();
    chk("lat_wload", {31'd0, ba.wload}, 32'd1);
    chk("lat_en", {31'd0, ba.mem_en}, 32'd0);
    chk("lat_sel", 32'(ba.mem_sel), 32'(1) << i);
    tick();
    chk("strt_cs", {31'd0, ba.conv_start}, 32'd1);
    for (int k = 0; k < dly; k++) begin
      if (noise && k == 1) ba.start = 1'b1;
      tick();
      ba.conv_done = 1'b0;
      ba.start = 1'b0;
      chk("wait_quiet", {29'd0, ba.conv_start, ba.wload, ba.mem_en}, 32'd0);
    end
    if (i < NFA - 1) sb_q.push_back(exp_rd(i + 1, 0));
    ba.conv_done = 1'b1;
    tick();
    ba.conv_done = 1'b0;
    if (i == NFA - 1) chk("fin_done", {31'd0, ba.done}, 32'd1);
    else chk("next_idx", 32'(ba.filter_idx), 32'(i + 1));
  endtask

  initial begin
    rst_n = 1'b0;
    ba.start = 1'b0; ba.abort = 1'b0; ba.conv_done = 1'b0;
    bb.start = 1'b0; bb.abort = 1'b0; bb.conv_done = 1'b0;
    #23;
    chk_all_zero("reset");
    rst_n = 1'b1;

    // start sampled at edge 10, then a 100-cycle stall in WAIT of filter 0
    while (cyc < 9) tick();
    sb_q.push_back(exp_rd(0, 0));
    ba.start = 1'b1;
    tick();
    ba.start = 1'b0;
    chk("c10_mem_en", {31'd0, ba.mem_en}, 32'd1);
    tick();
    chk("c11_wload", {31'd0, ba.wload}, 32'd1);
    tick();
    chk("c12_cs", {31'd0, ba.conv_start}, 32'd1);
    repeat (100) tick();
    chk("stall_idx", 32'(ba.filter_idx), 32'd0);
    chk("stall_busy", {31'd0, ba.busy}, 32'd1);
    chk("stall_quiet", {29'd0, ba.conv_start, ba.wload, ba.mem_en}, 32'd0);
    sb_q.push_back(exp_rd(1, 0));
    ba.conv_done = 1'b1;
    tick();
    ba.conv_done = 1'b0;
    one_filter(1, 5, 1'b1);
    one_filter(2, 5, 1'b0);
    one_filter(3, 5, 1'b0);
    tick();
    chk("p1_idle", {30'd0, ba.busy, ba.done}, 32'd0);
    chk("p1_counts", {wl_cnt[7:0], cs_cnt[7:0], dn_cnt[7:0]}, {8'd4, 8'd4, 8'd1});

    // clean pass, conv_done 5 cycles after each conv_start
    wl_cnt = 0; cs_cnt = 0; dn_cnt = 0;
    sb_q.push_back(exp_rd(0, 0));
    ba.start = 1'b1;
    tick();
    ba.start = 1'b0;
    for (int i = 0; i < NFA; i++) one_filter(i, 5, 1'b0);
    chk("fin_busy", {31'd0, ba.busy}, 32'd1);
    chk("fin_idx", 32'(ba.filter_idx), 32'd3);
    tick();
    chk("p2_idle", {30'd0, ba.busy, ba.done}, 32'd0);
    chk("p2_counts", {wl_cnt[7:0], cs_cnt[7:0], dn_cnt[7:0]}, {8'd4, 8'd4, 8'd1});

    // abort in WAIT of filter 2
    wl_cnt = 0; cs_cnt = 0; dn_cnt = 0;
    sb_q.push_back(exp_rd(0, 0));
    ba.start = 1'b1;
    tick();
    ba.start = 1'b0;
    one_filter(0, 3, 1'b0);
    one_filter(1, 3, 1'b0);
    chk("ab_idx", 32'(ba.filter_idx), 32'd2);
    repeat (4) tick();
    ba.abort = 1'b1;
    tick();
    ba.abort = 1'b0;
    chk("ab_pulse", {29'd0, ba.aborted, ba.done, ba.mem_en}, 32'd4);
    tick();
    chk("ab_idle", {30'd0, ba.busy, ba.aborted}, 32'd0);
    repeat (3) tick();
    chk("ab_no_done", 32'(dn_cnt), 32'd0);

    // start and abort together in IDLE
    ba.start = 1'b1;
    ba.abort = 1'b1;
    tick();
    ba.start = 1'b0;
    ba.abort = 1'b0;
    chk("sa_idle", {29'd0, ba.busy, ba.aborted, ba.mem_en}, 32'd0);
    tick();
    chk("sa_idle2", {31'd0, ba.busy}, 32'd0);

    // restart from filter 0, then async reset during RD of filter 1
    sb_q.push_back(exp_rd(0, 0));
    ba.start = 1'b1;
    tick();
    ba.start = 1'b0;
    chk("restart_idx", 32'(ba.filter_idx), 32'd0);
    one_filter(0, 2, 1'b0);
    chk("rd1_en", {31'd0, ba.mem_en}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    rst_n = 1'b1;
    tick();
    chk("post_rst", {29'd0, ba.busy, ba.done, ba.aborted}, 32'd0);
    chk("post_rst_done", 32'(dn_cnt), 32'd0);

    // single-filter instance with BASE_ADDR=3
    bb.start = 1'b1;
    tick();
    bb.start = 1'b0;
    chk("b_rd", {24'd0, bb.mem_en, bb.mem_addr, bb.mem_sel}, {24'd0, 1'b1, 4'd3, 1'b1});
    tick();
    chk("b_lat", {29'd0, bb.wload, bb.mem_en, bb.mem_sel}, 32'd5);
    tick();
    chk("b_cs", {31'd0, bb.conv_start}, 32'd1);
    repeat (3) tick();
    bb.conv_done = 1'b1;
    tick();
    bb.conv_done = 1'b0;
    chk("b_done", {30'd0, bb.done, bb.busy}, 32'd3);
    tick();
    chk("b_idle", {30'd0, bb.done, bb.busy}, 32'd0);

    chk("sb_left", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/filter_bank_scheduler.md
Name: filter_bank_scheduler

Overview:
- Sequences the per-filter weight memories (9 weights + 1 bias per filter, 10-word bank, 1-cycle registered read) through one convolution core, one filter at a time.
- For each filter: enables that bank's read, strobes the conv core to latch the 10 words, starts the convolution, waits for completion, then advances to the next filter.
- Sits between the top-level CNN control (start/done) and the filter banks plus conv core.

Parameters:
- NUM_FILTERS, 4, number of filter banks sequenced, indices 0..NUM_FILTERS-1.
- FILT_IDX_W, 2, width of filter index, ceil(log2(NUM_FILTERS)), minimum 1.
- addressWidthFilter, 4, width of filter-bank read address.
- BASE_ADDR, 0, word address of weight 0 in every bank. Words BASE_ADDR..BASE_ADDR+9 must lie inside the bank.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  pulse; begin a full pass over all filters.
- abort  input  1  level/pulse; cancel the pass in progress.
- conv_done  input  1  conv core finished the current filter.
- mem_en  output  1  read enable to the selected filter bank.
- mem_sel  output  NUM_FILTERS  one-hot bank select, qualifies mem_en per bank.
- mem_addr  output  addressWidthFilter  bank read address.
- wload  output  1  bank outputs valid; conv core latches rdata0..8 and bias this cycle.
- conv_start  output  1  one-cycle pulse starting the conv core.
- filter_idx  output  FILT_IDX_W  index of the filter being processed.
- busy  output  1  high whenever the state is not IDLE.
- done  output  1  one-cycle pulse; all filters completed.
- aborted  output  1  one-cycle pulse; pass cancelled by abort.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - All outputs go to 0: mem_sel=0, mem_addr=0, filter_idx=0.
  - Release is synchronous to clk.
- Outputs are registered Moore decodes: each output is valid during the cycle its state is held.
- FSM states: IDLE, RD, LAT, STRT, WAIT, FIN, ABRT.
- IDLE:
  - start=1 and abort=0 -> RD, and filter_idx<=0.
  - start=1 together with abort=1 -> stay IDLE; abort wins, no aborted pulse.
- RD (1 cycle):
  - mem_en=1, mem_sel=1<<filter_idx, mem_addr=BASE_ADDR.
  - -> LAT.
- LAT (1 cycle):
  - The bank registered its data at the end of RD, so wload=1 here.
  - mem_en=0, mem_sel holds its value, mem_addr holds its value.
  - -> STRT.
- STRT (1 cycle): conv_start=1 -> WAIT.
- WAIT:
  - Hold until conv_done=1.
  - On conv_done with filter_idx==NUM_FILTERS-1 -> FIN.
  - On conv_done otherwise -> filter_idx<=filter_idx+1, then RD.
- FIN (1 cycle): done=1 -> IDLE. filter_idx stays at its final value until the next start.
- conv_done is sampled only in WAIT; it is ignored in every other state, including a conv_done coincident with conv_start.
- start is ignored outside IDLE.
- abort in any state except IDLE or ABRT -> ABRT next cycle, suppressing every normal transition.
  - ABRT (1 cycle): aborted=1, all other strobes 0 -> IDLE.
  - No done pulse is produced after an abort.
- Latency:
  - start sampled at edge N: mem_en at N+1, wload at N+2, conv_start at N+3, WAIT from N+4.
  - conv_done sampled in WAIT at edge M: next RD at M+1, or done at M+1 for the last filter.
- Invariants:
  - wload and conv_start are never high together.
  - mem_sel is zero or one-hot; mem_en implies mem_sel!=0.
  - filter_idx never exceeds NUM_FILTERS-1; no wrap.
- Reset mid-pass: immediate return to IDLE with all outputs 0, no done or aborted pulse.

Test Plan:
- Reset, then start with NUM_FILTERS=4 and conv_done 5 cycles after each conv_start -> mem_sel sequence 0001, 0010, 0100, 1000 with mem_addr=0; exactly 4 wload and 4 conv_start pulses; done is a single pulse 1 cycle after the 4th conv_done; busy drops the same cycle as IDLE is re-entered.
- Start at cycle 10 -> mem_en high in cycle 11, wload in cycle 12, conv_start in cycle 13; hold conv_done low for 100 cycles -> stays in WAIT with filter_idx=0 and busy=1.
- Pulse start again during WAIT of filter 1, and drive conv_done during LAT/STRT -> both ignored; pass completes with exactly 4 filters.
- Abort during WAIT of filter 2 -> aborted pulse next cycle, then IDLE, busy=0, no done; a following start restarts at filter_idx=0.
- Start and abort asserted together in IDLE -> no state change, no aborted pulse; rst_n low during RD of filter 1 -> all outputs 0 immediately, asynchronously.
- BASE_ADDR=3, NUM_FILTERS=1 -> mem_addr=3 in RD, done after the single conv_done; assertion that mem_sel is never non-one-hot holds throughout.
